// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the ID/EX slice: ALU op codes, opcodes, control bundle
// and decode helpers for the arithmetic and branch funct3 fields.
package rv32i_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [31:0] NOP = 32'h00000013;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_AND    = 4'd2,
      ALU_OR     = 4'd3,
      ALU_XOR    = 4'd4,
      ALU_SLL    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_SLT    = 4'd8,
      ALU_SLTU   = 4'd9,
      ALU_EQ     = 4'd10,
      ALU_NE     = 4'd11,
      ALU_GE     = 4'd12,
      ALU_GEU    = 4'd13,
      ALU_PASS_B = 4'd14,
      ALU_NONE   = 4'd15
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    branch;
      logic    alu_src;
      alu_op_e alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{FALSE, FALSE, FALSE, FALSE, FALSE, ALU_NONE};

   // SUB only exists for register-register ops; SRA/SRAI share instr[30] as selector
   function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic funct7_b5,
                                        input logic is_reg);
      alu_op_e op;
      op = ALU_NONE;
      case (funct3)
         3'b000: op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
         3'b001: op = ALU_SLL;
         3'b010: op = ALU_SLT;
         3'b011: op = ALU_SLTU;
         3'b100: op = ALU_XOR;
         3'b101: op = funct7_b5 ? ALU_SRA : ALU_SRL;
         3'b110: op = ALU_OR;
         3'b111: op = ALU_AND;
         default: op = ALU_NONE;
      endcase
      return op;
   endfunction

   function automatic alu_op_e branch_op(input logic [2:0] funct3);
      alu_op_e op;
      op = ALU_NONE;
      case (funct3)
         3'b000: op = ALU_EQ;
         3'b001: op = ALU_NE;
         3'b100: op = ALU_SLT;
         3'b101: op = ALU_GE;
         3'b110: op = ALU_SLTU;
         3'b111: op = ALU_GEU;
         default: op = ALU_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational RV32I ALU: arithmetic, logic, shifts, compares and branch conditions.
import rv32i_pkg::*;

module rv32i_alu #(
   parameter int XLEN = 32
) (
   input  alu_op_e         alu_op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic [XLEN-1:0] result
);

   logic [4:0] shamt;

   assign shamt = src2[4:0];

   always_comb begin
      result = '0;
      case (alu_op)
         ALU_ADD:    result = src1 + src2;
         ALU_SUB:    result = src1 - src2;
         ALU_AND:    result = src1 & src2;
         ALU_OR:     result = src1 | src2;
         ALU_XOR:    result = src1 ^ src2;
         ALU_SLL:    result = src1 << shamt;
         ALU_SRL:    result = src1 >> shamt;
         ALU_SRA:    result = $signed(src1) >>> shamt;
         ALU_SLT:    result = XLEN'($signed(src1) < $signed(src2));
         ALU_SLTU:   result = XLEN'(src1 < src2);
         ALU_EQ:     result = XLEN'(src1 == src2);
         ALU_NE:     result = XLEN'(src1 != src2);
         ALU_GE:     result = XLEN'($signed(src1) >= $signed(src2));
         ALU_GEU:    result = XLEN'(src1 >= src2);
         ALU_PASS_B: result = src2;
         default:    result = '0;
      endcase
   end

endmodule

// File: rtl/rv32i_id_ex_unit.sv
// RV32I decode, ID/EX pipeline register and EX stage (forwarding + ALU + branch target).
// Define RV32I_ID_EX_FWD_EN to build the EX/MEM and MEM/WB forwarding muxes.
import rv32i_pkg::*;

module rv32i_id_ex_unit #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [31:0]     instr_raw,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_val,
   input  logic [XLEN-1:0] id_rs2_val,
   input  logic            flush,
   input  logic            mem_reg_write,
   input  logic            mem_mem_read,
   input  logic [4:0]      mem_rd_addr,
   input  logic [XLEN-1:0] mem_rd_val,
   input  logic [4:0]      wb_rd_addr,
   input  logic [XLEN-1:0] wb_rd_val,
   output logic [XLEN-1:0] ex_result,
   output logic [XLEN-1:0] ex_rs2_fwd,
   output logic [XLEN-1:0] ex_branch_addr,
   output logic [4:0]      ex_rd_addr,
   output logic            ex_branch,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_reg_write
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7_b5;
   ctrl_t           dec_ctrl;
   logic [XLEN-1:0] dec_imm;

   ctrl_t           ex_ctrl;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_imm;
   logic [4:0]      ex_rs1_addr;
   logic [4:0]      ex_rs2_addr;
   logic [XLEN-1:0] ex_rs1_val;
   logic [XLEN-1:0] ex_rs2_val;

   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;
   logic [XLEN-1:0] alu_src2;

   assign opcode    = instr_raw[6:0];
   assign funct3    = instr_raw[14:12];
   assign funct7_b5 = instr_raw[30];

   always_comb begin
      dec_ctrl = CTRL_NOP;
      dec_imm  = '0;
      case (opcode)
         OPC_OP: begin
            dec_ctrl.reg_write = TRUE;
            dec_ctrl.alu_op    = arith_op(funct3, funct7_b5, TRUE);
         end
         OPC_OP_IMM: begin
            dec_ctrl.reg_write = TRUE;
            dec_ctrl.alu_src   = TRUE;
            dec_ctrl.alu_op    = arith_op(funct3, funct7_b5, FALSE);
            dec_imm            = {{(XLEN-12){instr_raw[31]}}, instr_raw[31:20]};
         end
         OPC_LOAD: begin
            dec_ctrl.mem_read  = TRUE;
            dec_ctrl.reg_write = TRUE;
            dec_ctrl.alu_src   = TRUE;
            dec_ctrl.alu_op    = ALU_ADD;
            dec_imm            = {{(XLEN-12){instr_raw[31]}}, instr_raw[31:20]};
         end
         OPC_STORE: begin
            dec_ctrl.mem_write = TRUE;
            dec_ctrl.alu_src   = TRUE;
            dec_ctrl.alu_op    = ALU_ADD;
            dec_imm            = {{(XLEN-12){instr_raw[31]}}, instr_raw[31:25], instr_raw[11:7]};
         end
         OPC_BRANCH: begin
            dec_ctrl.branch = TRUE;
            dec_ctrl.alu_op = branch_op(funct3);
            dec_imm         = {{(XLEN-12){instr_raw[31]}}, instr_raw[7], instr_raw[30:25],
                               instr_raw[11:8], 1'b0};
         end
         OPC_LUI: begin
            // LUI routes the immediate through src2 so PASS_B can deliver it
            dec_ctrl.reg_write = TRUE;
            dec_ctrl.alu_src   = TRUE;
            dec_ctrl.alu_op    = ALU_PASS_B;
            dec_imm            = {instr_raw[31:12], 12'b0};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_ctrl     <= CTRL_NOP;
         ex_pc       <= '0;
         ex_imm      <= '0;
         ex_rs1_addr <= '0;
         ex_rs2_addr <= '0;
         ex_rs1_val  <= '0;
         ex_rs2_val  <= '0;
         ex_rd_addr  <= '0;
      end else begin
         ex_ctrl     <= flush ? CTRL_NOP : dec_ctrl;
         ex_pc       <= id_pc;
         ex_imm      <= dec_imm;
         ex_rs1_addr <= instr_raw[19:15];
         ex_rs2_addr <= instr_raw[24:20];
         ex_rs1_val  <= id_rs1_val;
         ex_rs2_val  <= id_rs2_val;
         ex_rd_addr  <= instr_raw[11:7];
      end
   end

`ifdef RV32I_ID_EX_FWD_EN
   // A load's EX/MEM value is only an address, so it must never be forwarded
   function automatic logic [XLEN-1:0] fwd_select(input logic [4:0] rs_addr,
                                                  input logic [XLEN-1:0] reg_val);
      logic [XLEN-1:0] val;
      val = reg_val;
      if (mem_reg_write && !mem_mem_read && (mem_rd_addr != 5'd0) && (mem_rd_addr == rs_addr))
         val = mem_rd_val;
      else if ((wb_rd_addr != 5'd0) && (wb_rd_addr == rs_addr))
         val = wb_rd_val;
      return val;
   endfunction

   assign fwd_rs1 = fwd_select(ex_rs1_addr, ex_rs1_val);
   assign fwd_rs2 = fwd_select(ex_rs2_addr, ex_rs2_val);
`else
   logic unused_fwd_inputs;

   assign unused_fwd_inputs = ^{mem_reg_write, mem_mem_read, mem_rd_addr, mem_rd_val,
                                wb_rd_addr, wb_rd_val, ex_rs1_addr, ex_rs2_addr};
   assign fwd_rs1 = ex_rs1_val;
   assign fwd_rs2 = ex_rs2_val;
`endif

   assign alu_src2       = ex_ctrl.alu_src ? ex_imm : fwd_rs2;
   assign ex_rs2_fwd     = fwd_rs2;
   assign ex_branch_addr = ex_pc + ex_imm;
   assign ex_branch      = ex_ctrl.branch;
   assign ex_mem_read    = ex_ctrl.mem_read;
   assign ex_mem_write   = ex_ctrl.mem_write;
   assign ex_reg_write   = ex_ctrl.reg_write;

   rv32i_alu #(.XLEN(XLEN)) u_alu (
      .alu_op (ex_ctrl.alu_op),
      .src1   (fwd_rs1),
      .src2   (alu_src2),
      .result (ex_result)
   );

endmodule

// File: tb/tb_rv32i_id_ex_unit.sv
// Directed bench for rv32i_id_ex_unit; expectations follow RV32I_ID_EX_FWD_EN if defined.
module tb_rv32i_id_ex_unit;

`ifdef RV32I_ID_EX_FWD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic [31:0] instr_raw;
   logic [31:0] id_pc;
   logic [31:0] id_rs1_val;
   logic [31:0] id_rs2_val;
   logic        flush;
   logic        mem_reg_write;
   logic        mem_mem_read;
   logic [4:0]  mem_rd_addr;
   logic [31:0] mem_rd_val;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_rd_val;
   logic [31:0] ex_result;
   logic [31:0] ex_rs2_fwd;
   logic [31:0] ex_branch_addr;
   logic [4:0]  ex_rd_addr;
   logic        ex_branch;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_reg_write;

   int checks = 0;
   int errors = 0;

   rv32i_id_ex_unit #(.XLEN(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .instr_raw      (instr_raw),
      .id_pc          (id_pc),
      .id_rs1_val     (id_rs1_val),
      .id_rs2_val     (id_rs2_val),
      .flush          (flush),
      .mem_reg_write  (mem_reg_write),
      .mem_mem_read   (mem_mem_read),
      .mem_rd_addr    (mem_rd_addr),
      .mem_rd_val     (mem_rd_val),
      .wb_rd_addr     (wb_rd_addr),
      .wb_rd_val      (wb_rd_val),
      .ex_result      (ex_result),
      .ex_rs2_fwd     (ex_rs2_fwd),
      .ex_branch_addr (ex_branch_addr),
      .ex_rd_addr     (ex_rd_addr),
      .ex_branch      (ex_branch),
      .ex_mem_read    (ex_mem_read),
      .ex_mem_write   (ex_mem_write),
      .ex_reg_write   (ex_reg_write)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Present one ID-stage instruction and step past the capture edge
   task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2);
      instr_raw  = instr;
      id_pc      = pc;
      id_rs1_val = rs1;
      id_rs2_val = rs2;
      @(posedge clock);
      #1;
   endtask

   task automatic set_fwd(input logic mrw, input logic mmr, input logic [4:0] mrd,
                          input logic [31:0] mval, input logic [4:0] wrd, input logic [31:0] wval);
      mem_reg_write = mrw;
      mem_mem_read  = mmr;
      mem_rd_addr   = mrd;
      mem_rd_val    = mval;
      wb_rd_addr    = wrd;
      wb_rd_val     = wval;
   endtask

   initial begin
      reset = 1'b0;
      flush = 1'b0;
      set_fwd(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0);
      $display("[TB] reset phase, forwarding build = %0d", FWD_ON);
      apply_stimulus(32'h00700293, 32'h0000_0004, 32'h0, 32'h0);
      @(posedge clock);
      #1;
      check_output("rst_result", ex_result, 32'h0);
      check_output("rst_rs2_fwd", ex_rs2_fwd, 32'h0);
      check_output("rst_branch_addr", ex_branch_addr, 32'h0);
      check_output("rst_rd_addr", {27'd0, ex_rd_addr}, 32'h0);
      check_output("rst_controls", {28'd0, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write}, 32'h0);

      reset = 1'b1;
      apply_stimulus(32'h00700293, 32'h0000_0004, 32'h0, 32'h0);
      check_output("addi_result", ex_result, 32'd7);
      check_output("addi_reg_write", {31'd0, ex_reg_write}, 32'd1);
      check_output("addi_rd_addr", {27'd0, ex_rd_addr}, 32'd5);
      check_output("addi_mem_read", {31'd0, ex_mem_read}, 32'd0);

      set_fwd(1'b1, 1'b0, 5'd5, 32'd10, 5'd6, 32'd20);
      apply_stimulus(32'h006283B3, 32'h0000_0008, 32'd3, 32'd4);
      check_output("add_fwd_both", ex_result, FWD_ON ? 32'd30 : 32'd7);
      check_output("add_rs2_fwd_wb", ex_rs2_fwd, FWD_ON ? 32'd20 : 32'd4);
      check_output("add_rd_addr", {27'd0, ex_rd_addr}, 32'd7);

      set_fwd(1'b1, 1'b0, 5'd5, 32'd10, 5'd5, 32'd20);
      #1;
      check_output("add_mem_priority", ex_result, FWD_ON ? 32'd14 : 32'd7);

      mem_mem_read = 1'b1;
      #1;
      check_output("add_load_no_mem_fwd", ex_result, FWD_ON ? 32'd24 : 32'd7);

      set_fwd(1'b1, 1'b0, 5'd0, 32'd99, 5'd0, 32'd55);
      apply_stimulus(32'h00700293, 32'h0000_000C, 32'h0, 32'h0);
      check_output("x0_never_fwd", ex_result, 32'd7);

      set_fwd(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0);
      apply_stimulus(32'hFE208CE3, 32'h0000_0020, 32'd9, 32'd9);
      check_output("beq_branch", {31'd0, ex_branch}, 32'd1);
      check_output("beq_result", ex_result, 32'd1);
      check_output("beq_target", ex_branch_addr, 32'h18);
      check_output("beq_reg_write", {31'd0, ex_reg_write}, 32'd0);

      apply_stimulus(32'hFE209CE3, 32'h0000_0020, 32'd9, 32'd9);
      check_output("bne_result", ex_result, 32'd0);
      check_output("bne_target", ex_branch_addr, 32'h18);

      apply_stimulus(32'h00612623, 32'h0000_0030, 32'h100, 32'hDEADBEEF);
      check_output("sw_mem_write", {31'd0, ex_mem_write}, 32'd1);
      check_output("sw_result", ex_result, 32'h10C);
      check_output("sw_rs2_fwd", ex_rs2_fwd, 32'hDEADBEEF);
      check_output("sw_reg_write", {31'd0, ex_reg_write}, 32'd0);

      flush = 1'b1;
      apply_stimulus(32'h00700293, 32'h0000_0034, 32'h0, 32'h0);
      flush = 1'b0;
      check_output("flush_reg_write", {31'd0, ex_reg_write}, 32'd0);
      check_output("flush_result", ex_result, 32'd0);
      check_output("flush_rd_addr", {27'd0, ex_rd_addr}, 32'd5);

      apply_stimulus(32'h4062D3B3, 32'h0000_0038, 32'h80000000, 32'd4);
      check_output("sra_result", ex_result, 32'hF8000000);

      apply_stimulus(32'h123452B7, 32'h0000_003C, 32'h0, 32'h0);
      check_output("lui_result", ex_result, 32'h12345000);
      check_output("lui_reg_write", {31'd0, ex_reg_write}, 32'd1);

      apply_stimulus(32'h00000000, 32'h0000_0040, 32'd5, 32'd6);
      check_output("illegal_controls", {28'd0, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write}, 32'h0);
      check_output("illegal_result", ex_result, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
